aes_operand_router: RTL and testbench

Registered, flow-controlled successor to the AES combinational operand selector. Routes one of three operand groups (key-schedule words W0/W1/W2, IV + 256-bit message, counter block + 256-bit message) onto three DW-bit output lanes. Adds per-source valid/ready handshakes, join semantics for two-source modes, a DEPTH-entry output FIFO with a mode tag, and a beat counter. Sits between the key-expansion/IV/counter producers and the AES round datapath.

---
 rtl/aes_operand_router_if.sv | 35 +++
 rtl/aes_operand_router.sv | 130 +++++++++++++
 tb/tb_aes_operand_router.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/aes_operand_router_if.sv
// Handshake/bus bundle for aes_operand_router: three operand sources, message source,
// FIFO head lanes with mode tag, beat counter and error flag.
interface aes_operand_router_if #(
    parameter int DW   = 128,
    parameter int CNTW = 16
);
    logic [1:0]      sel_i;
    logic [DW-1:0]   w0_i, w1_i, w2_i;
    logic            wvalid_i, wready_o;
    logic [DW-1:0]   iv_i;
    logic            ivalid_i, iready_o;
    logic [DW-1:0]   c_i;
    logic            cvalid_i, cready_o;
    logic [2*DW-1:0] m_i;
    logic            mvalid_i, mready_o;
    logic [DW-1:0]   out0_o, out1_o, out2_o;
    logic [1:0]      sel_o;
    logic            valid_o, ready_i;
    logic [CNTW-1:0] cnt_o;
    logic            err_o;

    modport slave (
        input  sel_i, w0_i, w1_i, w2_i, wvalid_i, iv_i, ivalid_i, c_i, cvalid_i,
               m_i, mvalid_i, ready_i,
        output wready_o, iready_o, cready_o, mready_o, out0_o, out1_o, out2_o,
               sel_o, valid_o, cnt_o, err_o
    );

    modport master (
        output sel_i, w0_i, w1_i, w2_i, wvalid_i, iv_i, ivalid_i, c_i, cvalid_i,
               m_i, mvalid_i, ready_i,
        input  wready_o, iready_o, cready_o, mready_o, out0_o, out1_o, out2_o,
               sel_o, valid_o, cnt_o, err_o
    );
endinterface

// File: rtl/aes_operand_router.sv
// Registered AES operand router: per-source handshakes, join for IV/C + message, tagged output FIFO.
// Optional sticky illegal-select flag built only when AES_ROUTER_ERR_EN is defined.
module aes_operand_router #(
    parameter int DW    = 128,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    aes_operand_router_if.slave bus
);
    localparam int NL = 3;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]              sel;
        logic [NL-1:0][DW-1:0]   lane;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_ent, head;
    logic [OW-1:0]   occ_q, occ_d;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            rdy_en_q;
    logic            space, push, pop, valid;
    logic            wready, iready, cready, mready;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // rdy_en_q holds source readies low for the first cycle after reset
    assign space = rst_ni & rdy_en_q & (occ_q < OW'(DEPTH));
    assign valid = (occ_q != '0);
    assign pop   = valid & bus.ready_i;

    always_comb begin
        wready      = 1'b0;
        iready      = 1'b0;
        cready      = 1'b0;
        mready      = 1'b0;
        push        = 1'b0;
        wr_ent      = '0;
        wr_ent.sel  = bus.sel_i;
        case (bus.sel_i)
            2'd0: begin
                wready         = space;
                push           = space & bus.wvalid_i;
                wr_ent.lane[0] = bus.w0_i;
                wr_ent.lane[1] = bus.w1_i;
                wr_ent.lane[2] = bus.w2_i;
            end
            2'd1: begin
                iready         = space & bus.mvalid_i;
                mready         = space & bus.ivalid_i;
                push           = space & bus.ivalid_i & bus.mvalid_i;
                wr_ent.lane[0] = bus.iv_i;
                wr_ent.lane[1] = bus.m_i[2*DW-1:DW];
                wr_ent.lane[2] = bus.m_i[DW-1:0];
            end
            2'd2: begin
                cready         = space & bus.mvalid_i;
                mready         = space & bus.cvalid_i;
                push           = space & bus.cvalid_i & bus.mvalid_i;
                wr_ent.lane[0] = bus.c_i;
                wr_ent.lane[1] = bus.m_i[2*DW-1:DW];
                wr_ent.lane[2] = bus.m_i[DW-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        occ_d  = occ_q + OW'(push) - OW'(pop);
        wptr_d = push ? inc_ptr(wptr_q) : wptr_q;
        rptr_d = pop  ? inc_ptr(rptr_q) : rptr_q;
        cnt_d  = cnt_q + CNTW'(push);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            occ_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wr_ent;
    end

    assign head = valid ? mem_q[rptr_q] : '0;

    assign bus.wready_o = wready;
    assign bus.iready_o = iready;
    assign bus.cready_o = cready;
    assign bus.mready_o = mready;
    assign bus.valid_o  = valid;
    assign bus.out0_o   = head.lane[0];
    assign bus.out1_o   = head.lane[1];
    assign bus.out2_o   = head.lane[2];
    assign bus.sel_o    = head.sel;
    assign bus.cnt_o    = cnt_q;

`ifdef AES_ROUTER_ERR_EN
    logic err_set, err_q;
    assign err_set = (bus.sel_i == 2'd3) &
                     (bus.wvalid_i | bus.ivalid_i | bus.cvalid_i | bus.mvalid_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni)      err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_aes_operand_router.sv
// Directed, table-driven bench for aes_operand_router (DEPTH=2, CNTW=4 to reach the counter wrap).
module tb_aes_operand_router;
    localparam int DW    = 128;
    localparam int DEPTH = 2;
    localparam int CNTW  = 4;
`ifdef AES_ROUTER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  vld;   // {wvalid, ivalid, cvalid, mvalid, ready_i}
        logic [23:0] abc;   // source bytes a, b, c
        logic [3:0]  erdy;  // {wready, iready, cready, mready} before the edge
        logic        evo;
        logic [47:0] eo;    // expected out0/out1/out2, 16 bits each
        logic [1:0]  esel;
        logic [3:0]  ecnt;
        logic        eerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [22];

    always #5 clk = ~clk;

    aes_operand_router_if #(.DW(DW), .CNTW(CNTW)) bus ();

    aes_operand_router #(.DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    function automatic vec_t mk(input logic [1:0] sel, input logic [4:0] vld,
                                input logic [23:0] abc, input logic [3:0] erdy,
                                input logic evo, input logic [47:0] eo,
                                input logic [1:0] esel, input logic [3:0] ecnt,
                                input logic eerr);
        vec_t v;
        v.sel = sel; v.vld = vld; v.abc = abc; v.erdy = erdy; v.evo = evo;
        v.eo = eo; v.esel = esel; v.ecnt = ecnt; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input int id,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.sel_i    = v.sel;
        bus.wvalid_i = v.vld[4];
        bus.ivalid_i = v.vld[3];
        bus.cvalid_i = v.vld[2];
        bus.mvalid_i = v.vld[1];
        bus.ready_i  = v.vld[0];
        bus.w0_i     = DW'(v.abc[23:16]);
        bus.w1_i     = DW'(v.abc[15:8]);
        bus.w2_i     = DW'(v.abc[7:0]);
        bus.iv_i     = DW'(16'h0100 | {8'h00, v.abc[23:16]});
        bus.c_i      = DW'(16'h0200 | {8'h00, v.abc[23:16]});
        bus.m_i      = {DW'(v.abc[15:8]), DW'(v.abc[7:0])};
    endtask

    task automatic chk_rdy(input int id, input logic [3:0] erdy);
        chk("ready", id, DW'({bus.wready_o, bus.iready_o, bus.cready_o, bus.mready_o}),
            DW'(erdy));
    endtask

    task automatic chk_out(input int id, input vec_t v);
        chk("valid", id, DW'(bus.valid_o), DW'(v.evo));
        chk("out0",  id, bus.out0_o, DW'(v.eo[47:32]));
        chk("out1",  id, bus.out1_o, DW'(v.eo[31:16]));
        chk("out2",  id, bus.out2_o, DW'(v.eo[15:0]));
        chk("sel_o", id, DW'(bus.sel_o), DW'(v.esel));
        chk("cnt",   id, DW'(bus.cnt_o), DW'(v.ecnt));
        chk("err",   id, DW'(bus.err_o), DW'(v.eerr & ERR_EN));
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic apply(input vec_t v, input int id);
        drive(v);
        #1 chk_rdy(id, v.erdy);
        @(posedge clk);
        #1 chk_out(id, v);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = mk(2'd0, 5'b10001, 24'h010203, 4'b0000, 1'b0, 48'h0, 2'd0, 4'd0, 1'b0);
        tbl[1]  = mk(2'd0, 5'b10001, 24'h010203, 4'b1000, 1'b1, 48'h0001_0002_0003, 2'd0, 4'd1, 1'b0);
        tbl[2]  = mk(2'd0, 5'b00001, 24'h000000, 4'b1000, 1'b0, 48'h0, 2'd0, 4'd1, 1'b0);
        tbl[3]  = mk(2'd1, 5'b11101, 24'h440A0B, 4'b0001, 1'b0, 48'h0, 2'd0, 4'd1, 1'b0);
        tbl[4]  = mk(2'd1, 5'b11101, 24'h440A0B, 4'b0001, 1'b0, 48'h0, 2'd0, 4'd1, 1'b0);
        tbl[5]  = mk(2'd1, 5'b11101, 24'h440A0B, 4'b0001, 1'b0, 48'h0, 2'd0, 4'd1, 1'b0);
        tbl[6]  = mk(2'd1, 5'b01011, 24'h440A0B, 4'b0101, 1'b1, 48'h0144_000A_000B, 2'd1, 4'd2, 1'b0);
        tbl[7]  = mk(2'd1, 5'b00001, 24'h000000, 4'b0000, 1'b0, 48'h0, 2'd0, 4'd2, 1'b0);
        tbl[8]  = mk(2'd2, 5'b00110, 24'h213141, 4'b0011, 1'b1, 48'h0221_0031_0041, 2'd2, 4'd3, 1'b0);
        tbl[9]  = mk(2'd2, 5'b00110, 24'h223242, 4'b0011, 1'b1, 48'h0221_0031_0041, 2'd2, 4'd4, 1'b0);
        tbl[10] = mk(2'd2, 5'b00110, 24'h233343, 4'b0000, 1'b1, 48'h0221_0031_0041, 2'd2, 4'd4, 1'b0);
        tbl[11] = mk(2'd2, 5'b00111, 24'h233343, 4'b0000, 1'b1, 48'h0222_0032_0042, 2'd2, 4'd4, 1'b0);
        tbl[12] = mk(2'd2, 5'b00111, 24'h233343, 4'b0011, 1'b1, 48'h0223_0033_0043, 2'd2, 4'd5, 1'b0);
        tbl[13] = mk(2'd0, 5'b00001, 24'h000000, 4'b1000, 1'b0, 48'h0, 2'd0, 4'd5, 1'b0);
        tbl[14] = mk(2'd0, 5'b10001, 24'h050607, 4'b1000, 1'b1, 48'h0005_0006_0007, 2'd0, 4'd6, 1'b0);
        tbl[15] = mk(2'd2, 5'b00111, 24'h556677, 4'b0011, 1'b1, 48'h0255_0066_0077, 2'd2, 4'd7, 1'b0);
        tbl[16] = mk(2'd0, 5'b10001, 24'h08090A, 4'b1000, 1'b1, 48'h0008_0009_000A, 2'd0, 4'd8, 1'b0);
        tbl[17] = mk(2'd2, 5'b00111, 24'h58697A, 4'b0011, 1'b1, 48'h0258_0069_007A, 2'd2, 4'd9, 1'b0);
        tbl[18] = mk(2'd0, 5'b00001, 24'h000000, 4'b1000, 1'b0, 48'h0, 2'd0, 4'd9, 1'b0);
        tbl[19] = mk(2'd3, 5'b10001, 24'h0A0B0C, 4'b0000, 1'b0, 48'h0, 2'd0, 4'd9, 1'b1);
        tbl[20] = mk(2'd3, 5'b00001, 24'h000000, 4'b0000, 1'b0, 48'h0, 2'd0, 4'd9, 1'b1);
        tbl[21] = mk(2'd0, 5'b00001, 24'h000000, 4'b1000, 1'b0, 48'h0, 2'd0, 4'd9, 1'b1);

        // Reset with a W source already valid: readies stay low
        rst_n = 1'b0;
        drive(mk(2'd0, 5'b10000, 24'h0, 4'b0, 1'b0, 48'h0, 2'd0, 4'd0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        chk_rdy(100, 4'b0000);
        chk_out(100, mk(2'd0, 5'b0, 24'h0, 4'b0, 1'b0, 48'h0, 2'd0, 4'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) apply(tbl[i], i);

        // Fill both entries under backpressure, then reset mid-stream
        apply(mk(2'd0, 5'b10000, 24'h111111, 4'b1000, 1'b1, 48'h0011_0011_0011, 2'd0, 4'd10, 1'b1), 200);
        apply(mk(2'd0, 5'b10000, 24'h121212, 4'b1000, 1'b1, 48'h0011_0011_0011, 2'd0, 4'd11, 1'b1), 201);
        rst_n = 1'b0;
        drive(mk(2'd0, 5'b10000, 24'h131313, 4'b0, 1'b0, 48'h0, 2'd0, 4'd0, 1'b0));
        #1 chk_rdy(202, 4'b0000);
        @(posedge clk);
        #1 chk_out(202, mk(2'd0, 5'b0, 24'h0, 4'b0, 1'b0, 48'h0, 2'd0, 4'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(2'd0, 5'b10001, 24'h121212, 4'b0000, 1'b0, 48'h0, 2'd0, 4'd0, 1'b0), 203);
        apply(mk(2'd0, 5'b10001, 24'h131415, 4'b1000, 1'b1, 48'h0013_0014_0015, 2'd0, 4'd1, 1'b0), 204);

        // Stream to the counter wrap at ready_i=1
        for (int i = 0; i < 14; i++) begin
            logic [7:0] a;
            a = 8'h20 + 8'(i);
            apply(mk(2'd0, 5'b10001, {a, 16'h0}, 4'b1000, 1'b1, {8'h00, a, 32'h0},
                     2'd0, 4'(2 + i), 1'b0), 300 + i);
        end
        apply(mk(2'd0, 5'b10001, 24'h400000, 4'b1000, 1'b1, 48'h0040_0000_0000, 2'd0, 4'd0, 1'b0), 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
